// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted presynaptic sum, shift leak, threshold fire, refractory hold.
// Weights live locally and are rewritten through a single-entry load port.
module lif_neuron #(
    parameter int NUM_PRE        = 5,
    parameter int W_WIDTH        = 8,
    parameter int V_WIDTH        = 12,
    parameter int THRESHOLD      = 200,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 4,
    parameter int W_INIT         = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_PRE-1:0] pre_spike,
    input  logic               w_load_en,
    input  logic [2:0]         w_load_idx,
    input  logic [W_WIDTH-1:0] w_load_val,
    output logic               post_spike,
    output logic [V_WIDTH-1:0] membrane,
    output logic [1:0]         state,
    output logic               refractory
);

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRACT   = 2'd2
    } state_t;

    // Two spare bits hold leaked potential plus a full all-inputs sum before clamping.
    localparam int ACC_W = V_WIDTH + 2;
    localparam int CNT_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = (REFRACT_CYCLES > 0) ? CNT_W'(REFRACT_CYCLES - 1) : '0;
    localparam logic [V_WIDTH-1:0] V_MAX    = '1;
    localparam logic [V_WIDTH-1:0] V_THRESH = V_WIDTH'(THRESHOLD);
    localparam logic [W_WIDTH-1:0] W_RESET  = W_WIDTH'(W_INIT);

    state_t               state_q, state_d;
    logic [V_WIDTH-1:0]   membrane_q, membrane_d;
    logic                 post_q, post_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [W_WIDTH-1:0]   weight_q [NUM_PRE];

    logic [ACC_W-1:0]     syn_sum;
    logic [V_WIDTH-1:0]   v_decayed;
    logic [ACC_W-1:0]     v_raw;
    logic [V_WIDTH-1:0]   v_next;

    always_comb begin
        syn_sum = '0;
        for (int i = 0; i < NUM_PRE; i++) begin
            if (pre_spike[i]) begin
                syn_sum = syn_sum + ACC_W'(weight_q[i]);
            end
        end
    end

    // Truncating leak: potentials below 2^LEAK_SHIFT never decay away on their own.
    always_comb begin
        v_decayed = membrane_q - (membrane_q >> LEAK_SHIFT);
        v_raw     = ACC_W'(v_decayed) + syn_sum;
        if (v_raw > ACC_W'(V_MAX)) begin
            v_next = V_MAX;
        end else begin
            v_next = v_raw[V_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        membrane_d = membrane_q;
        post_d     = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            ST_INTEGRATE: begin
                if (v_next >= V_THRESH) begin
                    membrane_d = '0;
                    state_d    = ST_FIRE;
                    post_d     = 1'b1;
                end else begin
                    membrane_d = v_next;
                end
            end
            ST_FIRE: begin
                membrane_d = '0;
                if (REFRACT_CYCLES > 0) begin
                    state_d = ST_REFRACT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_INTEGRATE;
                end
            end
            ST_REFRACT: begin
                membrane_d = '0;
                if (cnt_q == '0) begin
                    state_d = ST_INTEGRATE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                membrane_d = '0;
                state_d    = ST_INTEGRATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INTEGRATE;
            membrane_q <= '0;
            post_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            membrane_q <= membrane_d;
            post_q     <= post_d;
            cnt_q      <= cnt_d;
        end
    end

    // Out-of-range indices match no entry, so they fall through without effect.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PRE; i++) begin
            if (!rst_n) begin
                weight_q[i] <= W_RESET;
            end else if (w_load_en && (w_load_idx == 3'(i))) begin
                weight_q[i] <= w_load_val;
            end
        end
    end

    assign post_spike = post_q;
    assign membrane   = membrane_q;
    assign state      = state_q;
    assign refractory = (state_q == ST_REFRACT);

endmodule
